// File: rtl/pixel_pkg.sv
// Shared types and elaboration-time helpers for the pixel serializer and its prefetch FIFO.
package pixel_pkg;

  typedef enum logic [0:0] {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic int ppw_of(input int width, input int bpp);
    return width / bpp;
  endfunction

  // A single-pixel word still needs a one-bit index register.
  function automatic int idx_w_of(input int ppw);
    return (ppw > 1) ? $clog2(ppw) : 1;
  endfunction

  function automatic int cnt_w_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit cfg_ok(input int width, input int bpp, input int depth);
    return ((width % bpp) == 0) && (depth >= 1) &&
           ((bpp == 1) || (bpp == 2) || (bpp == 4) || (bpp == 8));
  endfunction

endpackage

// File: rtl/word_fifo.sv
// DEPTH x WIDTH first-word-fall-through FIFO with synchronous flush and async active-low reset.
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n_s;
    if (p == PTR_W'(DEPTH - 1)) begin
      n_s = {PTR_W{1'b0}};
    end else begin
      n_s = p + PTR_W'(1);
    end
    return n_s;
  endfunction

  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// Word-to-pixel serializer: prefetch FIFO feeding a shift word emitted BPP bits at a time,
// each pixel held for (mult+1) enabled cycles, with an explicit underrun flag instead of stale data.
module pixel_serializer
  import pixel_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BPP    = 1,
  parameter int DEPTH  = 2,
  parameter int MULT_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  d,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              load,
  input  logic              enable,
  input  logic [MULT_W-1:0] mult,
  input  logic              lsb_first,
  output logic [BPP-1:0]    q,
  output logic              q_valid,
  output logic              underrun
);

  localparam int PPW   = ppw_of(WIDTH, BPP);
  localparam int IDX_W = idx_w_of(PPW);
  localparam int CNT_W = cnt_w_of(DEPTH);

  if (!cfg_ok(WIDTH, BPP, DEPTH)) begin : g_cfg_err
    $error("pixel_serializer: WIDTH must be a multiple of BPP (1/2/4/8) and DEPTH >= 1");
  end

  state_e            state_r, state_nx_s;
  logic [WIDTH-1:0]  word_r, word_nx_s;
  logic              lsb_r, lsb_nx_s;
  logic [IDX_W-1:0]  idx_r, idx_nx_s;
  logic [MULT_W-1:0] rep_r, rep_nx_s;
  logic [BPP-1:0]    q_r, q_nx_s;
  logic              q_valid_r, q_valid_nx_s;
  logic              underrun_r, underrun_nx_s;

  logic [WIDTH-1:0]  fifo_dout_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;

  function automatic logic [BPP-1:0] pix_of(input logic [WIDTH-1:0] w,
                                            input logic [IDX_W-1:0] k,
                                            input logic             lsb);
    logic [WIDTH-1:0] sh_s;
    if (lsb) begin
      sh_s = w >> (int'(k) * BPP);
    end else begin
      sh_s = w >> (WIDTH - BPP - int'(k) * BPP);
    end
    return sh_s[BPP-1:0];
  endfunction

  assign d_ready = !load && (fifo_count_s < CNT_W'(DEPTH));
  assign push_s  = d_valid && !load && !fifo_full_s;

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (load),
    .push    (push_s),
    .pop     (pop_s),
    .din     (d),
    .dout    (fifo_dout_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Next-state: load beats enable; with enable low everything holds and underrun drops.
  always_comb begin
    state_nx_s    = state_r;
    word_nx_s     = word_r;
    lsb_nx_s      = lsb_r;
    idx_nx_s      = idx_r;
    rep_nx_s      = rep_r;
    q_nx_s        = q_r;
    q_valid_nx_s  = q_valid_r;
    underrun_nx_s = 1'b0;
    pop_s         = 1'b0;
    if (load) begin
      state_nx_s   = EMPTY;
      idx_nx_s     = {IDX_W{1'b0}};
      rep_nx_s     = {MULT_W{1'b0}};
      q_nx_s       = {BPP{1'b0}};
      q_valid_nx_s = 1'b0;
    end else if (enable) begin
      case (state_r)
        EMPTY: begin
          if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            word_nx_s    = fifo_dout_s;
            lsb_nx_s     = lsb_first;
            idx_nx_s     = {IDX_W{1'b0}};
            rep_nx_s     = {MULT_W{1'b0}};
            q_nx_s       = pix_of(fifo_dout_s, {IDX_W{1'b0}}, lsb_first);
            q_valid_nx_s = 1'b1;
            state_nx_s   = ACTIVE;
          end else begin
            q_nx_s       = {BPP{1'b0}};
            q_valid_nx_s = 1'b0;
          end
        end
        ACTIVE: begin
          // >= so that lowering mult mid-pixel ends the pixel instead of wrapping the counter.
          if (rep_r >= mult) begin
            rep_nx_s = {MULT_W{1'b0}};
            if (idx_r < IDX_W'(PPW - 1)) begin
              idx_nx_s = idx_r + IDX_W'(1);
              q_nx_s   = pix_of(word_r, idx_r + IDX_W'(1), lsb_r);
            end else if (!fifo_empty_s) begin
              pop_s     = 1'b1;
              word_nx_s = fifo_dout_s;
              lsb_nx_s  = lsb_first;
              idx_nx_s  = {IDX_W{1'b0}};
              q_nx_s    = pix_of(fifo_dout_s, {IDX_W{1'b0}}, lsb_first);
            end else begin
              q_nx_s        = {BPP{1'b0}};
              q_valid_nx_s  = 1'b0;
              underrun_nx_s = 1'b1;
              idx_nx_s      = {IDX_W{1'b0}};
              state_nx_s    = EMPTY;
            end
          end else begin
            rep_nx_s = rep_r + MULT_W'(1);
          end
        end
        default: begin
          state_nx_s   = EMPTY;
          q_nx_s       = {BPP{1'b0}};
          q_valid_nx_s = 1'b0;
        end
      endcase
    end else begin
      underrun_nx_s = 1'b0;
    end
  end

  // Serializer state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= EMPTY;
      word_r     <= {WIDTH{1'b0}};
      lsb_r      <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      rep_r      <= {MULT_W{1'b0}};
      q_r        <= {BPP{1'b0}};
      q_valid_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      word_r     <= word_nx_s;
      lsb_r      <= lsb_nx_s;
      idx_r      <= idx_nx_s;
      rep_r      <= rep_nx_s;
      q_r        <= q_nx_s;
      q_valid_r  <= q_valid_nx_s;
      underrun_r <= underrun_nx_s;
    end
  end

  assign q        = q_r;
  assign q_valid  = q_valid_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench: a 1-bpp instance for timing/handshake/load/reset sequences and a
// 2-bpp instance driven from a table of hand-computed vectors.
module tb_pixel_serializer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] d1, d2;
  logic        dv1, dv2, rdy1, rdy2, ld1, ld2, en1, en2, lsb1, lsb2;
  logic [3:0]  mult1, mult2;
  logic [0:0]  q1;
  logic [1:0]  q2;
  logic        qv1, qv2, und1, und2;

  pixel_serializer #(.WIDTH(16), .BPP(1), .DEPTH(2), .MULT_W(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .d(d1), .d_valid(dv1), .d_ready(rdy1), .load(ld1),
    .enable(en1), .mult(mult1), .lsb_first(lsb1), .q(q1), .q_valid(qv1), .underrun(und1)
  );

  pixel_serializer #(.WIDTH(16), .BPP(2), .DEPTH(2), .MULT_W(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .d(d2), .d_valid(dv2), .d_ready(rdy2), .load(ld2),
    .enable(en2), .mult(mult2), .lsb_first(lsb2), .q(q2), .q_valid(qv2), .underrun(und2)
  );

  typedef struct {
    logic [15:0] d;
    logic        dv;
    logic        en;
    logic        lsb;
    logic        ld;
    logic [1:0]  q;
    logic        qv;
    logic        und;
    logic        rdy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bits;
    logic [15:0] w;
    vec_t        vq[$];

    reset_n = 1'b0;
    d1 = 16'h0000; dv1 = 1'b0; ld1 = 1'b0; en1 = 1'b0; mult1 = 4'd0; lsb1 = 1'b0;
    d2 = 16'h0000; dv2 = 1'b0; ld2 = 1'b0; en2 = 1'b0; mult2 = 4'd0; lsb2 = 1'b0;
    cyc();
    cyc();
    chk("rst.q", q1, 1'b0);
    chk("rst.q_valid", qv1, 1'b0);
    chk("rst.underrun", und1, 1'b0);
    chk("rst.q2", q2, 2'd0);
    reset_n = 1'b1;
    #1;
    chk("rst.d_ready", rdy1, 1'b1);
    chk("rst.d_ready2", rdy2, 1'b1);

    // Fill the FIFO with enable low: exactly two words taken, then d_ready drops.
    cyc();
    d1 = 16'hA5F0; dv1 = 1'b1;
    cyc();
    chk("fill1.d_ready", rdy1, 1'b1);
    chk("fill1.q_valid", qv1, 1'b0);
    d1 = 16'h0F0F;
    cyc();
    chk("fill2.d_ready", rdy1, 1'b0);
    d1 = 16'h1234;
    cyc();
    chk("fill3.d_ready", rdy1, 1'b0);
    chk("fill3.q_valid", qv1, 1'b0);
    dv1 = 1'b0; en1 = 1'b1;

    // Two back-to-back words at mult=0: 32 gapless pixels, then one underrun pulse.
    bits = {16'hA5F0, 16'h0F0F};
    for (int i = 0; i < 32; i++) begin
      cyc();
      chk($sformatf("b2b%0d.q", i), q1, bits[31-i]);
      chk($sformatf("b2b%0d.q_valid", i), qv1, 1'b1);
      chk($sformatf("b2b%0d.underrun", i), und1, 1'b0);
      if (i == 0) chk("pop.d_ready", rdy1, 1'b1);
    end
    cyc();
    chk("b2b.underrun", und1, 1'b1);
    chk("b2b.end_q_valid", qv1, 1'b0);
    chk("b2b.end_q", q1, 1'b0);
    cyc();
    chk("b2b.underrun_clear", und1, 1'b0);

    // mult=2 on 0x8001: push at edge N gives pixel0 at edge N+1, each pixel 3 cycles.
    w = 16'h8001; d1 = w; dv1 = 1'b1; mult1 = 4'd2;
    cyc();
    chk("m2.latency_q_valid", qv1, 1'b0);
    dv1 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      chk($sformatf("m2_%0d.q", i), q1, w[15 - i / 3]);
      chk($sformatf("m2_%0d.q_valid", i), qv1, 1'b1);
      chk($sformatf("m2_%0d.underrun", i), und1, 1'b0);
    end
    cyc();
    chk("m2.underrun", und1, 1'b1);
    chk("m2.q_valid", qv1, 1'b0);
    cyc();
    chk("m2.underrun_clear", und1, 1'b0);

    // Load mid-word with the FIFO full; the word offered during load must not be taken.
    d1 = 16'hFFFF; dv1 = 1'b1; mult1 = 4'd0;
    cyc();
    cyc();
    cyc();
    chk("ld.pre_full", rdy1, 1'b0);
    chk("ld.pre_q_valid", qv1, 1'b1);
    d1 = 16'h1234; ld1 = 1'b1;
    #1;
    chk("ld.d_ready_during", rdy1, 1'b0);
    cyc();
    chk("ld.q", q1, 1'b0);
    chk("ld.q_valid", qv1, 1'b0);
    chk("ld.underrun", und1, 1'b0);
    ld1 = 1'b0; dv1 = 1'b0;
    #1;
    chk("ld.d_ready_after", rdy1, 1'b1);
    cyc();
    chk("ld.fifo_empty_q_valid", qv1, 1'b0);
    chk("ld.fifo_empty_underrun", und1, 1'b0);

    // 2-bpp vectors: lsb/msb order, word chaining, underrun, enable gating, load.
    vq.push_back('{16'h00E4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
    vq.push_back('{16'h00E4, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
    vq.push_back('{16'hC000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
    vq.push_back('{16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < vq.size(); i++) begin
      d2 = vq[i].d; dv2 = vq[i].dv; en2 = vq[i].en; lsb2 = vq[i].lsb; ld2 = vq[i].ld;
      cyc();
      chk($sformatf("tbl%0d.q", i), q2, vq[i].q);
      chk($sformatf("tbl%0d.q_valid", i), qv2, vq[i].qv);
      chk($sformatf("tbl%0d.underrun", i), und2, vq[i].und);
      chk($sformatf("tbl%0d.d_ready", i), rdy2, vq[i].rdy);
    end
    dv2 = 1'b0; en2 = 1'b0; ld2 = 1'b0;

    // Asynchronous reset in the middle of a word.
    d1 = 16'hFFFF; dv1 = 1'b1; en1 = 1'b1;
    cyc();
    dv1 = 1'b0;
    cyc();
    chk("arst.pre_q_valid", qv1, 1'b1);
    cyc();
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst.q", q1, 1'b0);
    chk("arst.q_valid", qv1, 1'b0);
    chk("arst.underrun", und1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("arst.d_ready", rdy1, 1'b1);
    cyc();
    chk("arst.post_q_valid", qv1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
